// File: rtl/mc_main_controller.sv
// rtl/mc_main_controller.sv - multi-cycle MIPS main control FSM (Moore) with PC load qualification
// Optional jal support is compiled in when MC_JAL_EN is defined.
module mc_main_controller #(
  parameter int OPC_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [OPC_W-1:0] opcode,
  input  logic             zero,
  output logic             pc_ld,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic [1:0]       reg_dst,
  output logic [1:0]       mem_to_reg,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       pc_src,
  output logic [1:0]       alu_op,
  output logic             illegal_op,
  output logic [3:0]       state
);

  localparam logic [OPC_W-1:0] OP_RTYPE = OPC_W'(6'b000000);
  localparam logic [OPC_W-1:0] OP_LW    = OPC_W'(6'b100011);
  localparam logic [OPC_W-1:0] OP_SW    = OPC_W'(6'b101011);
  localparam logic [OPC_W-1:0] OP_BEQ   = OPC_W'(6'b000100);
  localparam logic [OPC_W-1:0] OP_J     = OPC_W'(6'b000010);
  localparam logic [OPC_W-1:0] OP_ADDI  = OPC_W'(6'b001000);
  localparam logic [OPC_W-1:0] OP_SLTI  = OPC_W'(6'b001010);
`ifdef MC_JAL_EN
  localparam logic [OPC_W-1:0] OP_JAL   = OPC_W'(6'b000011);
`endif

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_LW_READ   = 4'd3,
    S_LW_WB     = 4'd4,
    S_SW_WRITE  = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BEQ       = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EXEC = 4'd10,
    S_SLTI_EXEC = 4'd11,
`ifdef MC_JAL_EN
    S_I_WB      = 4'd12,
    S_JAL       = 4'd13
`else
    S_I_WB      = 4'd12
`endif
  } state_t;

  state_t state_q;
  state_t state_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // Outputs are held at 0 for as long as reset is asserted, so an aborted
  // store or write-back cannot leak a strobe while the state register clears.
  always_comb begin
    state_d       = S_FETCH;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 2'b00;
    mem_to_reg    = 2'b00;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    pc_src        = 2'b00;
    alu_op        = 2'b00;
    illegal_op    = 1'b0;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          mem_read  = 1'b1;
          ir_write  = 1'b1;
          pc_write  = 1'b1;
          alu_src_b = 2'b01;
          state_d   = S_DECODE;
        end
        S_DECODE: begin
          alu_src_b = 2'b11;
          case (opcode)
            OP_RTYPE:     state_d = S_R_EXEC;
            OP_LW, OP_SW: state_d = S_MEM_ADDR;
            OP_BEQ:       state_d = S_BEQ;
            OP_J:         state_d = S_JUMP;
            OP_ADDI:      state_d = S_ADDI_EXEC;
            OP_SLTI:      state_d = S_SLTI_EXEC;
`ifdef MC_JAL_EN
            OP_JAL:       state_d = S_JAL;
`endif
            default: begin
              illegal_op = 1'b1;
              state_d    = S_FETCH;
            end
          endcase
        end
        S_MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          state_d   = (opcode == OP_LW) ? S_LW_READ : S_SW_WRITE;
        end
        S_LW_READ: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
          state_d  = S_LW_WB;
        end
        S_LW_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 2'b01;
        end
        S_SW_WRITE: begin
          mem_write = 1'b1;
          i_or_d    = 1'b1;
        end
        S_R_EXEC: begin
          alu_src_a = 1'b1;
          alu_op    = 2'b10;
          state_d   = S_R_WB;
        end
        S_R_WB: begin
          reg_write = 1'b1;
          reg_dst   = 2'b01;
        end
        S_BEQ: begin
          alu_src_a     = 1'b1;
          alu_op        = 2'b01;
          pc_src        = 2'b01;
          pc_write_cond = 1'b1;
        end
        S_JUMP: begin
          pc_src   = 2'b10;
          pc_write = 1'b1;
        end
        S_ADDI_EXEC: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          state_d   = S_I_WB;
        end
        S_SLTI_EXEC: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          alu_op    = 2'b11;
          state_d   = S_I_WB;
        end
        S_I_WB: begin
          reg_write = 1'b1;
        end
`ifdef MC_JAL_EN
        S_JAL: begin
          reg_write  = 1'b1;
          reg_dst    = 2'b10;
          mem_to_reg = 2'b10;
          pc_src     = 2'b10;
          pc_write   = 1'b1;
        end
`endif
        default: state_d = S_FETCH;
      endcase
    end
  end

  assign pc_ld = pc_write | (pc_write_cond & zero);
  assign state = state_q;

endmodule

// File: tb/tb_mc_main_controller.sv
// tb/tb_mc_main_controller.sv - directed self-checking bench for mc_main_controller
module tb_mc_main_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic       zero;
  logic       pc_ld, pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic [1:0] reg_dst, mem_to_reg;
  logic       reg_write, alu_src_a;
  logic [1:0] alu_src_b, pc_src, alu_op;
  logic       illegal_op;
  logic [3:0] state;
  logic [19:0] all_outs;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mc_main_controller #(.OPC_W(6)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
    .pc_ld(pc_ld), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .pc_src(pc_src), .alu_op(alu_op), .illegal_op(illegal_op), .state(state)
  );

  assign all_outs = {pc_ld, pc_write, pc_write_cond, i_or_d, mem_read, mem_write,
                     ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a,
                     alu_src_b, pc_src, alu_op, illegal_op};

  task automatic chk(input string tag, input logic [19:0] obs, input logic [19:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_fetch(input string tag);
    chk({tag, "_state"}, 20'(state), 20'd0);
    chk({tag, "_strobes"}, 20'({mem_read, ir_write, pc_write, pc_ld, mem_write, reg_write}), 20'b111100);
    chk({tag, "_srcb"}, 20'(alu_src_b), 20'd1);
    chk({tag, "_illegal"}, 20'(illegal_op), 20'd0);
  endtask

  initial begin
    rst    = 1'b1;
    opcode = 6'b000000;
    zero   = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_outs", all_outs, 20'd0);
    chk("rst_state", 20'(state), 20'd0);
    rst = 1'b0;
    #1;
    chk_fetch("fetch_after_rst");

    // sw, reset asserted in SW_WRITE
    opcode = 6'b101011;
    @(negedge clk);
    chk("sw_decode_state", 20'(state), 20'd1);
    chk("sw_decode_srcb", 20'(alu_src_b), 20'd3);
    @(negedge clk);
    chk("sw_addr_state", 20'(state), 20'd2);
    chk("sw_addr_src", 20'({alu_src_a, alu_src_b}), 20'b110);
    @(negedge clk);
    chk("sw_write_state", 20'(state), 20'd5);
    chk("sw_write_strobe", 20'({mem_write, i_or_d, reg_write}), 20'b110);
    rst = 1'b1;
    #1;
    chk("abort_mem_write", 20'(mem_write), 20'd0);
    chk("abort_outs", all_outs, 20'd0);
    chk("abort_state", 20'(state), 20'd0);
    @(negedge clk);
    chk("hold_rst_outs", all_outs, 20'd0);
    rst = 1'b0;
    #1;
    chk_fetch("fetch_after_abort");

    // lw: 0,1,2,3,4,0
    opcode = 6'b100011;
    @(negedge clk);
    chk("lw_s1", 20'(state), 20'd1);
    @(negedge clk);
    chk("lw_s2", 20'(state), 20'd2);
    @(negedge clk);
    chk("lw_s3", 20'(state), 20'd3);
    chk("lw_read", 20'({mem_read, i_or_d, mem_write}), 20'b110);
    @(negedge clk);
    chk("lw_s4", 20'(state), 20'd4);
    chk("lw_wb", 20'({reg_write, mem_to_reg, reg_dst}), 20'b10100);
    @(negedge clk);
    chk_fetch("lw_end");

    // beq not taken
    opcode = 6'b000100;
    zero   = 1'b0;
    @(negedge clk);
    chk("beq0_s1", 20'(state), 20'd1);
    @(negedge clk);
    chk("beq0_s8", 20'(state), 20'd8);
    chk("beq0_ctl", 20'({pc_write_cond, alu_src_a, alu_op, pc_src, pc_write}), 20'b1101010);
    chk("beq0_pc_ld", 20'(pc_ld), 20'd0);
    @(negedge clk);
    chk_fetch("beq0_end");

    // beq taken
    @(negedge clk);
    chk("beq1_s1", 20'(state), 20'd1);
    @(negedge clk);
    zero = 1'b1;
    #1;
    chk("beq1_s8", 20'(state), 20'd8);
    chk("beq1_ctl", 20'({alu_op, pc_src}), 20'b0101);
    chk("beq1_pc_ld", 20'(pc_ld), 20'd1);
    @(negedge clk);
    zero = 1'b0;
    chk("beq1_end", 20'(state), 20'd0);

    // R-type
    opcode = 6'b000000;
    @(negedge clk);
    chk("r_s1", 20'(state), 20'd1);
    @(negedge clk);
    chk("r_s6", 20'(state), 20'd6);
    chk("r_exec", 20'({alu_op, alu_src_a, alu_src_b}), 20'b10100);
    @(negedge clk);
    chk("r_s7", 20'(state), 20'd7);
    chk("r_wb", 20'({reg_write, reg_dst, mem_to_reg}), 20'b10100);
    @(negedge clk);
    chk("r_end", 20'(state), 20'd0);

    // slti
    opcode = 6'b001010;
    @(negedge clk);
    @(negedge clk);
    chk("slti_s11", 20'(state), 20'd11);
    chk("slti_exec", 20'({alu_op, alu_src_a, alu_src_b}), 20'b11110);
    @(negedge clk);
    chk("slti_s12", 20'(state), 20'd12);
    chk("slti_wb", 20'({reg_write, reg_dst, mem_to_reg}), 20'b10000);
    @(negedge clk);
    chk("slti_end", 20'(state), 20'd0);

    // addi
    opcode = 6'b001000;
    @(negedge clk);
    @(negedge clk);
    chk("addi_s10", 20'(state), 20'd10);
    chk("addi_exec", 20'({alu_op, alu_src_a, alu_src_b}), 20'b00110);
    @(negedge clk);
    chk("addi_s12", 20'(state), 20'd12);
    @(negedge clk);
    chk("addi_end", 20'(state), 20'd0);

    // j
    opcode = 6'b000010;
    @(negedge clk);
    @(negedge clk);
    chk("j_s9", 20'(state), 20'd9);
    chk("j_ctl", 20'({pc_write, pc_src, pc_ld, reg_write}), 20'b11010);
    @(negedge clk);
    chk("j_end", 20'(state), 20'd0);

    // illegal opcode
    opcode = 6'b111111;
    @(negedge clk);
    chk("ill_s1", 20'(state), 20'd1);
    chk("ill_pulse", 20'(illegal_op), 20'd1);
    chk("ill_no_write", 20'({mem_write, reg_write, pc_write, pc_ld}), 20'd0);
    @(negedge clk);
    chk_fetch("ill_end");

    // opcode 000011
    opcode = 6'b000011;
    @(negedge clk);
    chk("jal_s1", 20'(state), 20'd1);
`ifdef MC_JAL_EN
    chk("jal_no_illegal", 20'(illegal_op), 20'd0);
    @(negedge clk);
    chk("jal_s13", 20'(state), 20'd13);
    chk("jal_ctl", 20'({reg_write, reg_dst, mem_to_reg, pc_src, pc_write}), 20'b11010101);
    @(negedge clk);
    chk_fetch("jal_end");
`else
    chk("jal_illegal", 20'(illegal_op), 20'd1);
    chk("jal_no_write", 20'({reg_write, reg_dst, mem_to_reg}), 20'd0);
    @(negedge clk);
    chk_fetch("jal_end");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
